fmax_reduce: RTL and testbench
==============================

FMAX_REDUCE -- requirements
Module: fmax_reduce

Interface
REQ-001 Parameter CNT_W, default 8: width of element counter (and index output when enabled).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream element valid.
REQ-005 in_data  input  32  IEEE-754 single-precision element.
REQ-006 in_last  input  1  marks final element of current vector; qualified by in_valid.
REQ-007 in_ready  output  1  block can accept an element this cycle.
REQ-008 out_valid  output  1  reduction result available.
REQ-009 out_data  output  32  maximum of the vector.
REQ-010 out_nan  output  1  vector contained at least one NaN.
REQ-011 out_count  output  CNT_W  number of elements accepted, saturating.
REQ-012 out_ready  input  1  downstream accepts result.

Function
REQ-013 Transfer occurs on a rising edge where in_valid and in_ready are both high; likewise out_valid and out_ready for results.
REQ-014 FSM states: IDLE, ACCUM, DONE; in_ready = 1 in IDLE and ACCUM, 0 in DONE and while rst_n is low.
REQ-015 IDLE, on accept: acc <= in_data, count <= 1, nan <= NaN(in_data); next state DONE if in_last, else ACCUM.
REQ-016 ACCUM, on accept: acc <= max(acc, in_data), count <= count+1 saturating at 2^CNT_W-1, nan <= nan | NaN(in_data); next DONE if in_last, else stay.
REQ-017 DONE: out_valid = 1, out_data = acc, out_nan = nan, out_count = count; on out_ready -> IDLE; outputs held stable while out_ready low.
REQ-018 Latency: out_valid asserts on the cycle after the last element is accepted; minimum one idle cycle between result transfer and next vector's first accept is not required (IDLE accepts immediately).
REQ-019 NaN test: exponent 8'hFF and mantissa != 0; infinities are ordinary values.
REQ-020 max(a,b), a = acc, priority order: (1) either NaN -> 32'hFFC00000; (2) both zero (exp 0, mantissa 0) -> {a.sign, 31'b0}; (3) a == b -> a; (4) signs differ -> the positive operand; (5) both positive -> larger {exp,mantissa}; (6) both negative -> smaller {exp,mantissa}; magnitude ties keep a.
REQ-021 Once acc is NaN it remains 32'hFFC00000 for the rest of the vector.
REQ-022 Denormals compared by raw {exp,mantissa}, no flushing.
REQ-023 in_last on first element of a vector yields a one-element result equal to in_data bit-exact (NaN payload included: no canonicalisation on single element).

Reset
REQ-024 rst_n low: state IDLE, acc 0, count 0, nan 0, out_valid 0, out_data 0, out_nan 0, out_count 0, immediately and asynchronously.
REQ-025 Reset mid-ACCUM or in DONE discards partial/pending result; no output transfer occurs.
REQ-026 Release of rst_n is synchronised by the integrator; block accepts from the first rising edge with rst_n high.

Configuration
REQ-027 Macro FMAX_REDUCE_IDX_EN defined: adds output out_idx [CNT_W-1:0], 0-based position of the element selected as acc (updated only when max(acc,in_data) selects in_data; first NaN's index when NaN occurs, then frozen), reset 0, valid with out_valid.
REQ-028 FMAX_REDUCE_IDX_EN undefined: out_idx port and its logic absent; all other behaviour identical.

Verification
REQ-029 Stream 3F800000, C0000000, 40600000(last) -> out_data 40600000, out_count 3, out_nan 0, out_idx 2 (IDX_EN).
REQ-030 Stream C0400000, BF800000(last) -> out_data BF800000, out_idx 1; stream 80000000, 00000000(last) -> out_data 80000000, out_idx 0.
REQ-031 Stream 3F800000, 7FC00001, 40000000(last) -> out_data FFC00000, out_nan 1, out_idx 1.
REQ-032 Single element 7F800000 with in_last -> out_valid next cycle, out_data 7F800000, out_count 1.
REQ-033 Result pending, out_ready low 5 cycles -> out_valid/out_data stable, in_ready 0; out_ready high one cycle -> transfer, IDLE, in_ready 1.
REQ-034 rst_n pulsed low after 2 elements in ACCUM -> all outputs 0 immediately; next vector 40000000(last) -> out_data 40000000, out_count 1.

Source files
------------

// File: rtl/fmax_reduce.sv
// Streaming IEEE-754 single-precision max reduction with NaN flag and saturating element count.
// Define FMAX_REDUCE_IDX_EN to add out_idx, the position of the element currently held as the maximum.
module fmax_reduce #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_nan,
    output logic [CNT_W-1:0] out_count,
`ifdef FMAX_REDUCE_IDX_EN
    output logic [CNT_W-1:0] out_idx,
`endif
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [31:0]      QNAN      = 32'hFFC00000;
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t           state;
    state_t           state_next;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic             nan;
    logic             accept;
    logic             acc_nan;
    logic             in_nan;
    logic             acc_zero;
    logic             in_zero;
    logic             take_in;
    logic [31:0]      max_val;

    assign acc_nan  = (acc[30:23] == 8'hFF) && (acc[22:0] != 23'd0);
    assign in_nan   = (in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0);
    assign acc_zero = (acc[30:0] == 31'd0);
    assign in_zero  = (in_data[30:0] == 31'd0);
    assign accept   = in_valid && in_ready;

    // take_in also marks the first NaN so the index register can latch its position
    always_comb begin
        take_in = 1'b0;
        max_val = acc;
        if (acc_nan || in_nan) begin
            take_in = in_nan && !acc_nan;
            max_val = QNAN;
        end else if (acc_zero && in_zero) begin
            max_val = {acc[31], 31'b0};
        end else begin
            if (acc != in_data) begin
                if (acc[31] != in_data[31]) begin
                    take_in = acc[31];
                end else if (!acc[31]) begin
                    take_in = (in_data[30:0] > acc[30:0]);
                end else begin
                    take_in = (in_data[30:0] < acc[30:0]);
                end
            end
            max_val = take_in ? in_data : acc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_next = in_last ? DONE : ACCUM;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state != DONE);
        out_valid = (state == DONE);
        out_data  = out_valid ? acc : 32'd0;
        out_nan   = out_valid && nan;
        out_count = out_valid ? count : '0;
    end

    // The first element is stored raw so a one-element NaN keeps its payload
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= 32'd0;
            count <= '0;
            nan   <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                acc   <= in_data;
                count <= CNT_W'(1);
                nan   <= in_nan;
            end else begin
                acc   <= max_val;
                count <= (count == COUNT_MAX) ? count : count + CNT_W'(1);
                nan   <= nan | in_nan;
            end
        end
    end

`ifdef FMAX_REDUCE_IDX_EN
    logic [CNT_W-1:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                idx <= '0;
            end else if (take_in) begin
                idx <= count;
            end
        end
    end

    assign out_idx = out_valid ? idx : '0;
`endif

endmodule

// File: tb/tb_fmax_reduce.sv
// Self-checking bench for fmax_reduce: a vector-level max model scored at every result
// transfer, plus hand-computed literal checks on directed streams.
module tb_fmax_reduce;

    typedef struct packed {
        logic [31:0] data;
        logic        nan;
        logic [7:0]  count;
        logic [7:0]  idx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_nan;
    logic [7:0]  out_count;
    logic [7:0]  out_idx;
    logic        out_ready;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    fmax_reduce #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_nan   (out_nan),
        .out_count (out_count),
`ifdef FMAX_REDUCE_IDX_EN
        .out_idx   (out_idx),
`endif
        .out_ready (out_ready)
    );

`ifndef FMAX_REDUCE_IDX_EN
    assign out_idx = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit isNan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Map float bits onto an unsigned key whose integer order is the numeric order
    function automatic logic [31:0] orderKey(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h80000000);
    endfunction

    function automatic exp_t modelVector(input logic [31:0] v[$]);
        exp_t r;
        int   firstNan;
        r.data   = v[0];
        r.idx    = 8'd0;
        r.count  = (v.size() > 255) ? 8'd255 : 8'(v.size());
        r.nan    = 1'b0;
        firstNan = -1;
        for (int i = 0; i < v.size(); i++) begin
            if (isNan(v[i]) && firstNan < 0) firstNan = i;
        end
        if (firstNan >= 0) begin
            r.nan  = 1'b1;
            r.idx  = 8'(firstNan);
            r.data = (v.size() == 1) ? v[0] : 32'hFFC00000;
        end else begin
            for (int i = 1; i < v.size(); i++) begin
                if (!(r.data[30:0] == 31'd0 && v[i][30:0] == 31'd0) &&
                    orderKey(v[i]) > orderKey(r.data)) begin
                    r.data = v[i];
                    r.idx  = 8'(i);
                end
            end
        end
        return r;
    endfunction

    // Score every result transfer against the model
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("model_data", out_data, e.data);
                checkOutput("model_nan", 32'(out_nan), 32'(e.nan));
                checkOutput("model_count", 32'(out_count), 32'(e.count));
`ifdef FMAX_REDUCE_IDX_EN
                checkOutput("model_idx", 32'(out_idx), 32'(e.idx));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] v[$], input bit withLast);
        for (int i = 0; i < v.size(); i++) begin
            int waitCycles;
            in_valid   = 1'b1;
            in_data    = v[i];
            in_last    = withLast && (i == v.size() - 1);
            waitCycles = 0;
            @(negedge clk);
            while (!in_ready && waitCycles < 50) begin
                @(negedge clk);
                waitCycles++;
            end
            checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (withLast) expQ.push_back(modelVector(v));
    endtask

    task automatic waitResult();
        @(negedge clk);
        checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic [31:0] data, input logic nan,
                               input logic [7:0] count, input logic [7:0] idx);
        checkOutput({tag, "_data"}, out_data, data);
        checkOutput({tag, "_nan"}, 32'(out_nan), 32'(nan));
        checkOutput({tag, "_count"}, 32'(out_count), 32'(count));
`ifdef FMAX_REDUCE_IDX_EN
        checkOutput({tag, "_idx"}, 32'(out_idx), 32'(idx));
`else
        if (idx != 8'd0) checkOutput({tag, "_idx_absent"}, 32'(out_idx), 32'd0);
`endif
    endtask

    task automatic releaseResult();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("after_release_valid", 32'(out_valid), 32'd0);
        checkOutput("after_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_data"}, out_data, 32'd0);
        checkOutput({tag, "_nan"}, 32'(out_nan), 32'd0);
        checkOutput({tag, "_count"}, 32'(out_count), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_idx"}, 32'(out_idx), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] v[$];
        logic [31:0] hold;
        logic [31:0] pool[12];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1, -2, 3.5 -> 3.5, then hold the result with out_ready low
        v = '{32'h3F800000, 32'hC0000000, 32'h40600000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("basic", 32'h40600000, 1'b0, 8'd3, 8'd2);
        hold = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_data", out_data, hold);
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        releaseResult();

        v = '{32'hC0400000, 32'hBF800000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("neg", 32'hBF800000, 1'b0, 8'd2, 8'd1);
        releaseResult();

        v = '{32'h80000000, 32'h00000000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("zeros", 32'h80000000, 1'b0, 8'd2, 8'd0);
        releaseResult();

        v = '{32'h3F800000, 32'h7FC00001, 32'h40000000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("nan", 32'hFFC00000, 1'b1, 8'd3, 8'd1);
        releaseResult();

        v = '{32'h7F800000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("single_inf", 32'h7F800000, 1'b0, 8'd1, 8'd0);
        releaseResult();

        v = '{32'h7FC00001};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("single_nan", 32'h7FC00001, 1'b1, 8'd1, 8'd0);
        releaseResult();

        v = '{32'h00000001, 32'h00400000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("denorm_pos", 32'h00400000, 1'b0, 8'd2, 8'd1);
        releaseResult();

        v = '{32'h80000005, 32'h80000003, 32'h80000004};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("denorm_neg", 32'h80000003, 1'b0, 8'd3, 8'd1);
        releaseResult();

        // Reset mid-accumulation discards the partial vector
        v = '{32'h41000000, 32'h41100000};
        applyStimulus(v, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset_accum");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        v = '{32'h40000000};
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("after_reset", 32'h40000000, 1'b0, 8'd1, 8'd0);
        releaseResult();

        // Reset with a pending result drops it
        v = '{32'h42000000, 32'h41000000};
        applyStimulus(v, 1'b1);
        waitResult();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetOutputs("reset_done");
        void'(expQ.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Count saturates at 255; maximum sits at position 5
        v = {};
        for (int i = 0; i < 260; i++) v.push_back((i == 5) ? 32'h42000000 : 32'h3F800000);
        applyStimulus(v, 1'b1);
        waitResult();
        checkResult("saturate", 32'h42000000, 1'b0, 8'd255, 8'd5);
        releaseResult();

        // Back-to-back vectors from a pool of awkward values, scored by the model only
        pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                 32'h7F800000, 32'hFF800000, 32'h00000001, 32'h80000001,
                 32'h7FC00000, 32'h40490FDB, 32'hC2C80000, 32'h7F800001};
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            int len;
            len = $urandom_range(1, 6);
            v = {};
            for (int i = 0; i < len; i++) v.push_back(pool[$urandom_range(0, 11)]);
            applyStimulus(v, 1'b1);
        end
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("drain_queue", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
